// File: rtl/tx_burst_shaper.sv
// TX burst shaper: linear ramp-up/ramp-down envelope plus Q2.14 gain with saturation.
// Two-stage I/Q pipeline; the envelope and the latched gain are owned by a registered FSM.
module tx_burst_shaper #(
  parameter int RAMP_LOG2 = 6
) (
  input  logic        GCLK,
  input  logic        reset,
  input  logic        TX_EN,
  input  logic [15:0] GAIN,
  input  logic [31:0] DIN,
  input  logic        DIN_VALID,
  output logic [31:0] DOUT,
  output logic        DOUT_VALID,
  output logic        TX_BUSY,
  output logic        BURST_DONE
);

  localparam int EW  = RAMP_LOG2 + 1;
  localparam int M1W = 16 + RAMP_LOG2 + 2;
  localparam logic [EW-1:0] RL = {1'b1, {RAMP_LOG2{1'b0}}};

  typedef enum logic [1:0] {IDLE, RAMP_UP, ON, RAMP_DOWN} state_t;

  state_t        state_q;
  logic [EW-1:0] env_q;
  logic [EW-1:0] envInc_d;
  logic [EW-1:0] envDec_d;
  logic [15:0]   gain_q;
  logic          busy_q;
  logic          done_q;
  logic          valid1_q;
  logic          valid2_q;
  logic [15:0]   s1I_q;
  logic [15:0]   s1Q_q;
  logic [15:0]   doutI_q;
  logic [15:0]   doutQ_q;

  assign envInc_d = env_q + EW'(1);
  assign envDec_d = env_q - EW'(1);

  // Envelope scaling: the product never exceeds |x| * RL, so the shifted value fits 16 bits.
  function automatic logic signed [15:0] scaleEnv(input logic signed [15:0] x,
                                                  input logic [EW-1:0] e);
    logic signed [M1W-1:0] p;
    logic signed [M1W-1:0] sh;
    p  = M1W'(x) * M1W'($signed({1'b0, e}));
    sh = p >>> RAMP_LOG2;
    return sh[15:0];
  endfunction

  function automatic logic signed [15:0] applyGain(input logic signed [15:0] s,
                                                   input logic [15:0] g);
    logic signed [32:0] p;
    logic signed [32:0] sh;
    p  = 33'(s) * 33'($signed({1'b0, g}));
    sh = p >>> 14;
    if (sh > 33'sd32767)
      return 16'sh7FFF;
    else if (sh < -33'sd32768)
      return 16'sh8000;
    else
      return sh[15:0];
  endfunction

  // Envelope FSM; a ramp reversal keeps the current env so the amplitude never jumps.
  always_ff @(posedge GCLK) begin
    if (reset) begin
      state_q <= IDLE;
      env_q   <= '0;
      gain_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          env_q <= '0;
          if (TX_EN) begin
            state_q <= RAMP_UP;
            gain_q  <= GAIN;
            busy_q  <= 1'b1;
          end
        end
        RAMP_UP: begin
          if (DIN_VALID && env_q != RL)
            env_q <= envInc_d;
          if (!TX_EN)
            state_q <= RAMP_DOWN;
          else if (env_q == RL || (DIN_VALID && envInc_d == RL))
            state_q <= ON;
        end
        ON: begin
          if (!TX_EN)
            state_q <= RAMP_DOWN;
        end
        RAMP_DOWN: begin
          if (TX_EN) begin
            state_q <= RAMP_UP;
            if (DIN_VALID && env_q != '0)
              env_q <= envDec_d;
          end else if (env_q == '0 || (DIN_VALID && envDec_d == '0)) begin
            env_q   <= '0;
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (DIN_VALID) begin
            env_q <= envDec_d;
          end
        end
        default: begin
          state_q <= IDLE;
          env_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Data registers advance only on qualified samples; the valid bits always shift.
  always_ff @(posedge GCLK) begin
    if (reset) begin
      valid1_q <= 1'b0;
      valid2_q <= 1'b0;
      s1I_q    <= '0;
      s1Q_q    <= '0;
      doutI_q  <= '0;
      doutQ_q  <= '0;
    end else begin
      valid1_q <= DIN_VALID;
      valid2_q <= valid1_q;
      if (DIN_VALID) begin
        s1I_q <= scaleEnv(DIN[15:0], env_q);
        s1Q_q <= scaleEnv(DIN[31:16], env_q);
      end
      if (valid1_q) begin
        doutI_q <= applyGain(s1I_q, gain_q);
        doutQ_q <= applyGain(s1Q_q, gain_q);
      end
    end
  end

  assign DOUT       = {doutQ_q, doutI_q};
  assign DOUT_VALID = valid2_q;
  assign TX_BUSY    = busy_q;
  assign BURST_DONE = done_q;

endmodule
